// File: rtl/sphere_scan_controller_if.sv
// Bus between the scan controller, its requester/consumer, the sphere table
// and the shared collision unit.
interface sphere_scan_controller_if #(
    parameter int IDX_W = 3
);
    // Handshake: start is a one-shot request, honoured only while busy=0 and
    // never queued. ray/num_active must be valid in that same cycle. done
    // pulses for one cycle when hit/hit_idx/t_hit are valid. Those outputs
    // then hold until the next accepted start.
    logic              start;
    logic [191:0]      ray;
    logic [IDX_W:0]    num_active;
    logic [IDX_W-1:0]  sphere_addr;
    logic [191:0]      sphere_data;
    logic [191:0]      cd_sphere;
    logic [191:0]      cd_ray;
    logic [63:0]       cd_tbest;
    logic [63:0]       cd_tnew;
    logic              cd_collide;
    logic              busy;
    logic              done;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [63:0]       t_hit;

    modport slave (
        input  start, ray, num_active, sphere_data, cd_tnew, cd_collide,
        output sphere_addr, cd_sphere, cd_ray, cd_tbest, busy, done, hit,
        hit_idx, t_hit
    );

    modport master (
        output start, ray, num_active, sphere_data, cd_tnew, cd_collide,
        input  sphere_addr, cd_sphere, cd_ray, cd_tbest, busy, done, hit,
        hit_idx, t_hit
    );
endinterface

// File: rtl/sphere_scan_controller.sv
// Walks the sphere table for one ray, feeding the shared collision unit and
// keeping the nearest hit with t > 0.
module sphere_scan_controller #(
    parameter int NUM_SPHERES = 8,
    parameter int IDX_W       = 3,
    parameter int CD_LAT      = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    sphere_scan_controller_if.slave      bus,
    output logic [2:0]                   o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [63:0] TMAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam int          CNT_W = $clog2(CD_LAT + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [191:0]       r_ray;
    logic [191:0]       r_sphere;
    logic [63:0]        r_tbest;
    logic [63:0]        r_t_hit;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_hit_idx;
    logic               r_hit;
    logic [IDX_W:0]     r_num;
    logic [CNT_W-1:0]   r_wait;

    logic [IDX_W:0]     w_num_clamped;
    logic               w_last;
    logic               w_eval_final;
    logic               w_accept;

    assign w_num_clamped = (bus.num_active > (IDX_W+1)'(NUM_SPHERES))
                           ? (IDX_W+1)'(NUM_SPHERES) : bus.num_active;
    assign w_last        = ({1'b0, r_idx} == (r_num - (IDX_W+1)'(1)));
    assign w_eval_final  = (r_state == S_EVAL) && (r_wait == CNT_W'(1));
    // Strict less-than keeps the lower index on equal distances.
    assign w_accept      = bus.cd_collide
                           && ($signed(bus.cd_tnew) > 64'sd0)
                           && ($signed(bus.cd_tnew) < $signed(r_tbest));

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = (w_num_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_EVAL;
            S_EVAL: begin
                if (w_eval_final) begin
                    w_next_state = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ray     <= '0;
            r_sphere  <= '0;
            r_tbest   <= TMAX;
            r_t_hit   <= TMAX;
            r_idx     <= '0;
            r_hit_idx <= '0;
            r_hit     <= 1'b0;
            r_num     <= '0;
            r_wait    <= '0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ray     <= bus.ray;
                        r_num     <= w_num_clamped;
                        r_tbest   <= TMAX;
                        r_t_hit   <= TMAX;
                        r_idx     <= '0;
                        r_hit_idx <= '0;
                        r_hit     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_sphere <= bus.sphere_data;
                    r_wait   <= CNT_W'(CD_LAT);
                end
                S_EVAL: begin
                    r_wait <= r_wait - CNT_W'(1);
                    if (w_eval_final) begin
                        if (w_accept) begin
                            r_tbest   <= bus.cd_tnew;
                            r_hit_idx <= r_idx;
                            r_hit     <= 1'b1;
                        end
                        // t_hit is published on entry to DONE so it is valid with done.
                        if (w_last) begin
                            r_t_hit <= w_accept ? bus.cd_tnew : r_tbest;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sphere_addr = r_idx;
    assign bus.cd_sphere   = r_sphere;
    assign bus.cd_ray      = r_ray;
    assign bus.cd_tbest    = r_tbest;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.hit         = r_hit;
    assign bus.hit_idx     = r_hit_idx;
    assign bus.t_hit       = r_t_hit;
    assign o_state         = r_state;

endmodule
